// File: rtl/seatbelt_chime.sv
// Seatbelt chime driver.
// Debounces the Alarm level, then pulses Chime for a bounded number of beeps
// while Lamp stays lit for the whole episode. Ack mutes the chime but never the
// lamp. Dropping Alarm ends the episode and clears everything.
//
// Ports:
//   Clk     - clock, rising edge
//   RstN    - asynchronous active-low reset
//   Alarm   - warning request level
//   Ack     - driver mute request (level)
//   Chime   - buzzer drive (registered)
//   Lamp    - warning lamp (registered)
//   Expired - high once all beeps completed without Ack (registered)
//   BeepCnt - beeps started in the current episode (registered)
module seatbelt_chime #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned ON_CYC       = 8,
  parameter int unsigned OFF_CYC      = 8,
  parameter int unsigned MAX_BEEPS    = 6,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       Clk,
  input  logic       RstN,
  input  logic       Alarm,
  input  logic       Ack,
  output logic       Chime,
  output logic       Lamp,
  output logic       Expired,
  output logic [3:0] BeepCnt
);

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] OnLast  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OffLast = CNT_W'(OFF_CYC - 1);
  localparam logic [3:0]       BeepMax = 4'(MAX_BEEPS);

  typedef enum logic [2:0] {
    StIdle,
    StQual,
    StBeepOn,
    StBeepOff,
    StHold
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] timer;
  logic             ack_able;

  // Ack only takes effect while the chime sequence is live.
  assign ack_able = (state == StQual) || (state == StBeepOn) || (state == StBeepOff);

  // Outputs are assigned alongside the state they belong to, so they always
  // reflect the state entered on this edge.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state   <= StIdle;
      timer   <= '0;
      Chime   <= 1'b0;
      Lamp    <= 1'b0;
      Expired <= 1'b0;
      BeepCnt <= 4'd0;
    end else if (!Alarm) begin
      state   <= StIdle;
      timer   <= '0;
      Chime   <= 1'b0;
      Lamp    <= 1'b0;
      Expired <= 1'b0;
      BeepCnt <= 4'd0;
    end else if (Ack && ack_able) begin
      state <= StHold;
      Chime <= 1'b0;
      Lamp  <= 1'b1;
    end else begin
      case (state)
        StIdle: begin
          state <= StQual;
          timer <= '0;
        end
        StQual: begin
          if (timer == DebLast) begin
            state   <= StBeepOn;
            timer   <= '0;
            BeepCnt <= 4'd1;
            Chime   <= 1'b1;
            Lamp    <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StBeepOn: begin
          if (timer == OnLast) begin
            state <= StBeepOff;
            timer <= '0;
            Chime <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StBeepOff: begin
          if (timer == OffLast) begin
            timer <= '0;
            if (BeepCnt == BeepMax) begin
              state   <= StHold;
              Expired <= 1'b1;
            end else begin
              state   <= StBeepOn;
              BeepCnt <= BeepCnt + 4'd1;
              Chime   <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StHold: begin
          // Wait for Alarm to clear; Ack has no further effect.
        end
        default: begin
          state   <= StIdle;
          timer   <= '0;
          Chime   <= 1'b0;
          Lamp    <= 1'b0;
          Expired <= 1'b0;
          BeepCnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seatbelt_chime.sv
// Directed bench for seatbelt_chime with default parameters.
// Inputs change and outputs are sampled on the falling clock edge; edge_n is
// the index of the last rising edge passed, counted from the first edge that
// samples Alarm=1 in IDLE.
module tb_seatbelt_chime;

  logic       clk;
  logic       rst_n;
  logic       alarm;
  logic       ack;
  logic       chime;
  logic       lamp;
  logic       expired;
  logic [3:0] beep_cnt;

  int checks;
  int failures;
  int edge_n;

  seatbelt_chime dut (
    .Clk    (clk),
    .RstN   (rst_n),
    .Alarm  (alarm),
    .Ack    (ack),
    .Chime  (chime),
    .Lamp   (lamp),
    .Expired(expired),
    .BeepCnt(beep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pk(input logic c, input logic l, input logic e,
                                    input logic [3:0] b);
    return {c, l, e, b};
  endfunction

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] got;
    got = {chime, lamp, expired, beep_cnt};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d got chime/lamp/exp/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
             tag, edge_n, got[6], got[5], got[4], got[3:0], exp[6], exp[5], exp[4],
             exp[3:0]);
    end
  endtask

  task automatic adv_to(input int e);
    while (edge_n < e) begin
      @(negedge clk);
      edge_n++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    edge_n   = -1;
    rst_n    = 1'b0;
    alarm    = 1'b1;
    ack      = 1'b0;

    // Reset held with Alarm high: everything stays clear.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_hold", pk(0, 0, 0, 4'd0));
    end
    rst_n  = 1'b1;
    edge_n = -1;
    adv_to(3);
    chk("post_reset_qual", pk(0, 0, 0, 4'd0));
    adv_to(4);
    chk("post_reset_beep1", pk(1, 1, 0, 4'd1));
    alarm = 1'b0;
    adv_to(5);
    chk("post_reset_drop", pk(0, 0, 0, 4'd0));

    // Short pulse: Alarm on edges 0..3 only.
    alarm  = 1'b1;
    edge_n = -1;
    adv_to(3);
    chk("debounce_mid", pk(0, 0, 0, 4'd0));
    alarm = 1'b0;
    adv_to(4);
    chk("debounce_drop", pk(0, 0, 0, 4'd0));
    adv_to(8);
    chk("debounce_idle", pk(0, 0, 0, 4'd0));

    // Full run to expiry.
    alarm  = 1'b1;
    edge_n = -1;
    adv_to(3);
    chk("full_e3", pk(0, 0, 0, 4'd0));
    adv_to(4);
    chk("full_e4", pk(1, 1, 0, 4'd1));
    adv_to(11);
    chk("full_e11", pk(1, 1, 0, 4'd1));
    adv_to(12);
    chk("full_e12", pk(0, 1, 0, 4'd1));
    adv_to(19);
    chk("full_e19", pk(0, 1, 0, 4'd1));
    adv_to(20);
    chk("full_e20", pk(1, 1, 0, 4'd2));
    adv_to(52);
    chk("full_e52", pk(1, 1, 0, 4'd4));
    adv_to(84);
    chk("full_e84", pk(1, 1, 0, 4'd6));
    adv_to(91);
    chk("full_e91", pk(1, 1, 0, 4'd6));
    adv_to(92);
    chk("full_e92", pk(0, 1, 0, 4'd6));
    adv_to(99);
    chk("full_e99", pk(0, 1, 0, 4'd6));
    adv_to(100);
    chk("full_e100", pk(0, 1, 1, 4'd6));
    adv_to(110);
    chk("full_hold", pk(0, 1, 1, 4'd6));
    ack = 1'b1;
    adv_to(112);
    chk("full_hold_ack", pk(0, 1, 1, 4'd6));
    ack   = 1'b0;
    alarm = 1'b0;
    adv_to(113);
    chk("full_drop", pk(0, 0, 0, 4'd0));
    ack = 1'b1;
    adv_to(116);
    chk("idle_ack_ignored", pk(0, 0, 0, 4'd0));
    ack = 1'b0;

    // Mute during beep 1.
    alarm  = 1'b1;
    edge_n = -1;
    adv_to(9);
    chk("mute_pre", pk(1, 1, 0, 4'd1));
    ack = 1'b1;
    adv_to(10);
    chk("mute_e10", pk(0, 1, 0, 4'd1));
    ack = 1'b0;
    adv_to(30);
    chk("mute_held", pk(0, 1, 0, 4'd1));
    ack = 1'b1;
    adv_to(31);
    ack = 1'b0;
    adv_to(110);
    chk("mute_no_expire", pk(0, 1, 0, 4'd1));
    alarm = 1'b0;
    adv_to(111);
    chk("mute_drop", pk(0, 0, 0, 4'd0));

    // Drop during beep 3, then a fresh episode.
    alarm  = 1'b1;
    edge_n = -1;
    adv_to(39);
    chk("drop_pre", pk(1, 1, 0, 4'd3));
    alarm = 1'b0;
    adv_to(40);
    chk("drop_e40", pk(0, 0, 0, 4'd0));
    alarm  = 1'b1;
    edge_n = -1;
    adv_to(3);
    chk("rearm_e3", pk(0, 0, 0, 4'd0));
    adv_to(4);
    chk("rearm_e4", pk(1, 1, 0, 4'd1));

    // Asynchronous reset while the chime is on.
    adv_to(6);
    chk("areset_pre", pk(1, 1, 0, 4'd1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_now", pk(0, 0, 0, 4'd0));
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = -1;
    adv_to(3);
    chk("areset_qual", pk(0, 0, 0, 4'd0));
    adv_to(4);
    chk("areset_beep1", pk(1, 1, 0, 4'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
